// File: rtl/adc_spi_master.sv
// Byte-wide SPI master for ADC register reads/writes: one byte per spitxdv/spirxdv handshake.
// Chip select belongs to the command processor; this block only drives sclk and mosi.

module adc_spi_master #(
  parameter int unsigned SPI_MODE          = 0,
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spitx,
  input  logic       spitxdv,
  output logic       spitxready,
  output logic [7:0] spirx,
  output logic       spirxdv,
  output logic       spibusy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic Cpol = ((SPI_MODE >> 1) & 32'd1) != 0;
  localparam logic Cpha = (SPI_MODE & 32'd1) != 0;
  localparam int unsigned CntW = (CLKS_PER_HALF_BIT > 2) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic            rst_hold_q;
  logic [CntW-1:0] half_cnt_q, half_cnt_d;
  logic [4:0]      edge_cnt_q, edge_cnt_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic [7:0]      spirx_q, spirx_d;
  logic            spirxdv_q, spirxdv_d;

  // rst_hold_q keeps spitxready low for the cycle right after a reset edge.
  assign spitxready = ((state_q == StIdle) || (state_q == StDone)) && !rst_hold_q;
  assign spibusy    = (state_q == StShift);
  assign spirx      = spirx_q;
  assign spirxdv    = spirxdv_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    spirx_d    = spirx_q;
    spirxdv_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (spitxdv && spitxready) begin
          state_d    = StShift;
          tx_d       = spitx;
          // Starting at 1 places edge k exactly k*H cycles after the request cycle.
          half_cnt_d = CntW'(1);
          edge_cnt_d = 5'd0;
          if (!Cpha) begin
            mosi_d = spitx[7];
          end
        end
      end

      StShift: begin
        if (edge_cnt_q == 5'd16) begin
          state_d   = StDone;
          sclk_d    = Cpol;
          spirx_d   = rx_q;
          spirxdv_d = 1'b1;
        end else if (half_cnt_q == CntMax) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 5'd1;
          if (!edge_cnt_q[0]) begin
            // Leading edge.
            if (Cpha) begin
              mosi_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end else begin
              rx_d = {rx_q[6:0], miso};
            end
          end else begin
            // Trailing edge; CPHA=0 leaves mosi alone on the final edge.
            if (Cpha) begin
              rx_d = {rx_q[6:0], miso};
            end else if (edge_cnt_q != 5'd15) begin
              mosi_d = tx_q[6];
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rst_hold_q <= 1'b1;
      half_cnt_q <= '0;
      edge_cnt_q <= 5'd0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      sclk_q     <= Cpol;
      mosi_q     <= 1'b0;
      spirx_q    <= 8'h00;
      spirxdv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_hold_q <= 1'b0;
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      spirx_q    <= spirx_d;
      spirxdv_q  <= spirxdv_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: three instances (mode 0/H=2, mode 1/H=3, mode 3/H=3) checked
// against an SPI slave model, edge-timing formulas and handshake rules.

module tb_adc_spi_master;

  localparam int NI = 3;

  function automatic int h_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction
  function automatic logic cpol_of(input int i);
    return (i == 2);
  endfunction
  function automatic logic cpha_of(input int i);
    return (i != 0);
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] spitx      [NI];
  logic       spitxdv    [NI];
  logic       spitxready [NI];
  logic [7:0] spirx      [NI];
  logic       spirxdv    [NI];
  logic       spibusy    [NI];
  logic       sclk       [NI];
  logic       mosi       [NI];
  logic       miso       [NI];
  logic       miso_r     [NI];
  int         src        [NI];  // 0: slave model, 1: loopback, 2: tied high

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Monitor-owned records
  int         n_edge   [NI] = '{default: 0};
  int         edge_cyc [NI][1024];
  int         n_bit    [NI] = '{default: 0};
  logic       mosi_bit [NI][1024];
  int         n_rxdv   [NI] = '{default: 0};
  int         rxdv_cyc [NI][64];
  logic [7:0] rxdv_val [NI][64];
  logic       rxdv_rdy [NI][64];
  int         mosi_bad [NI] = '{default: 0};
  int         hold_bad [NI] = '{default: 0};
  int         sbit     [NI] = '{default: 0};
  logic       sclk_prev[NI];
  logic       mosi_prev[NI];
  logic [7:0] spirx_prev[NI];

  // Stimulus-owned slave byte stream
  logic [7:0] slave_byte [NI][64];
  int         n_slave    [NI];
  int         sbase      [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      case (src[i])
        1:       miso[i] = mosi[i];
        2:       miso[i] = 1'b1;
        default: miso[i] = miso_r[i];
      endcase
    end
  end

  adc_spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) u_m0 (
    .clk(clk), .rst(rst), .spitx(spitx[0]), .spitxdv(spitxdv[0]), .spitxready(spitxready[0]),
    .spirx(spirx[0]), .spirxdv(spirxdv[0]), .spibusy(spibusy[0]), .sclk(sclk[0]),
    .mosi(mosi[0]), .miso(miso[0])
  );
  adc_spi_master #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(3)) u_m1 (
    .clk(clk), .rst(rst), .spitx(spitx[1]), .spitxdv(spitxdv[1]), .spitxready(spitxready[1]),
    .spirx(spirx[1]), .spirxdv(spirxdv[1]), .spibusy(spibusy[1]), .sclk(sclk[1]),
    .mosi(mosi[1]), .miso(miso[1])
  );
  adc_spi_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(3)) u_m3 (
    .clk(clk), .rst(rst), .spitx(spitx[2]), .spitxdv(spitxdv[2]), .spitxready(spitxready[2]),
    .spirx(spirx[2]), .spirxdv(spirxdv[2]), .spibusy(spibusy[2]), .sclk(sclk[2]),
    .mosi(mosi[2]), .miso(miso[2])
  );

  // Bus monitor plus SPI slave: slave captures mosi on its sample edge, shifts miso otherwise.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit ed, ld;
      int idx;
      if (rst) begin
        sclk_prev[i]  = sclk[i];
        mosi_prev[i]  = mosi[i];
        spirx_prev[i] = spirx[i];
      end else begin
        ed = (sclk[i] !== sclk_prev[i]);
        ld = ed && (sclk[i] !== cpol_of(i));
        if (ed) begin
          if (n_edge[i] < 1024) edge_cyc[i][n_edge[i]] = cyc;
          n_edge[i]++;
          if (ld != cpha_of(i)) begin
            if (n_bit[i] < 1024) mosi_bit[i][n_bit[i]] = mosi[i];
            n_bit[i]++;
          end else begin
            sbit[i]++;
          end
        end
        if (cpha_of(i) && (mosi[i] !== mosi_prev[i]) && !ld) mosi_bad[i]++;
        if ((spirx[i] !== spirx_prev[i]) && (spirxdv[i] !== 1'b1)) hold_bad[i]++;
        if (spirxdv[i] === 1'b1 && n_rxdv[i] < 64) begin
          rxdv_cyc[i][n_rxdv[i]] = cyc;
          rxdv_val[i][n_rxdv[i]] = spirx[i];
          rxdv_rdy[i][n_rxdv[i]] = spitxready[i];
          n_rxdv[i]++;
        end
        sclk_prev[i]  = sclk[i];
        mosi_prev[i]  = mosi[i];
        spirx_prev[i] = spirx[i];
      end
      idx = sbit[i] - sbase[i] - (cpha_of(i) ? 1 : 0);
      if (idx >= 0 && (idx / 8) < n_slave[i]) miso_r[i] = slave_byte[i][idx / 8][7 - (idx % 8)];
      else miso_r[i] = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int i, input logic [7:0] tx, output int t);
    int w;
    w = 0;
    while (spitxready[i] !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    t = -1;
    if (w < 200) begin
      spitx[i]   = tx;
      spitxdv[i] = 1'b1;
      t = cyc;
      tick();
      spitxdv[i] = 1'b0;
      spitx[i]   = 8'($urandom);
    end
  endtask

  task automatic wait_rxdv(input int i, input int target, output bit ok);
    int w;
    w = 0;
    while (n_rxdv[i] < target && w < 500) begin
      tick();
      w++;
    end
    ok = (n_rxdv[i] >= target);
  endtask

  function automatic logic [7:0] bits_byte(input int i, input int b0);
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < 8; k++) v = {v[6:0], mosi_bit[i][b0 + k]};
    return v;
  endfunction

  task automatic realign(input int i);
    n_slave[i] = 0;
    sbase[i]   = sbit[i];
  endtask

  task automatic test_reset();
    logic [12:0] got, exp;
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      got = {spitxready[i], spibusy[i], spirxdv[i], spirx[i], sclk[i], mosi[i]};
      exp = {3'b000, 8'h00, cpol_of(i), 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got %b want %b", i, got, exp);
      end
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (spitxready[i] !== 1'b1 || spibusy[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release[%0d]: ready=%b busy=%b want 1/0", i, spitxready[i],
                 spibusy[i]);
      end
    end
  endtask

  task automatic test_mode0_loopback();
    int t, e0, b0, r0, nbad;
    bit ok;
    src[0] = 1;
    e0 = n_edge[0]; b0 = n_bit[0]; r0 = n_rxdv[0];
    start(0, 8'hA5, t);
    wait_rxdv(0, r0 + 1, ok);
    n_vec++;
    if (!ok || rxdv_cyc[0][r0] != t + 33) begin
      n_err++;
      $display("FAIL m0_latency: got cycle %0d want %0d (done=%0b)", rxdv_cyc[0][r0], t + 33, ok);
    end
    n_vec++;
    if (rxdv_val[0][r0] !== 8'hA5 || rxdv_rdy[0][r0] !== 1'b1) begin
      n_err++;
      $display("FAIL m0_rx: spirx=%h ready=%b want a5/1", rxdv_val[0][r0], rxdv_rdy[0][r0]);
    end
    nbad = 0;
    for (int k = 1; k <= 16; k++) if (edge_cyc[0][e0 + k - 1] != t + 2 * k) nbad++;
    n_vec++;
    if (n_edge[0] - e0 != 16 || nbad != 0) begin
      n_err++;
      $display("FAIL m0_edges: count=%0d misplaced=%0d want 16/0", n_edge[0] - e0, nbad);
    end
    n_vec++;
    if (n_bit[0] - b0 != 8 || bits_byte(0, b0) !== 8'hA5) begin
      n_err++;
      $display("FAIL m0_mosi: bits=%0d byte=%h want 8/a5", n_bit[0] - b0, bits_byte(0, b0));
    end
    tick();
    n_vec++;
    if (sclk[0] !== 1'b0) begin
      n_err++;
      $display("FAIL m0_sclk_idle: got %b want 0", sclk[0]);
    end
  endtask

  task automatic test_mode13();
    int t, e0, b0, r0, mb0, nbad, h;
    bit ok;
    for (int i = 1; i < NI; i++) begin
      h = h_of(i);
      src[i] = 2;
      e0 = n_edge[i]; b0 = n_bit[i]; r0 = n_rxdv[i]; mb0 = mosi_bad[i];
      n_vec++;
      if (sclk[i] !== cpol_of(i)) begin
        n_err++;
        $display("FAIL m%0d_sclk_before: got %b want %b", i, sclk[i], cpol_of(i));
      end
      start(i, 8'h3C, t);
      wait_rxdv(i, r0 + 1, ok);
      n_vec++;
      if (!ok || rxdv_cyc[i][r0] != t + 16 * h + 1 || rxdv_val[i][r0] !== 8'hFF) begin
        n_err++;
        $display("FAIL m%0d_rx: cycle %0d spirx %h want cycle %0d spirx ff", i,
                 rxdv_cyc[i][r0], rxdv_val[i][r0], t + 16 * h + 1);
      end
      nbad = 0;
      for (int k = 1; k <= 16; k++) if (edge_cyc[i][e0 + k - 1] != t + h * k) nbad++;
      n_vec++;
      if (n_edge[i] - e0 != 16 || nbad != 0) begin
        n_err++;
        $display("FAIL m%0d_edges: count=%0d misplaced=%0d want 16/0", i, n_edge[i] - e0, nbad);
      end
      n_vec++;
      if (bits_byte(i, b0) !== 8'h3C || mosi_bad[i] != mb0) begin
        n_err++;
        $display("FAIL m%0d_mosi: byte=%h off-edge changes=%0d want 3c/0", i, bits_byte(i, b0),
                 mosi_bad[i] - mb0);
      end
      tick();
      n_vec++;
      if (sclk[i] !== cpol_of(i)) begin
        n_err++;
        $display("FAIL m%0d_sclk_after: got %b want %b", i, sclk[i], cpol_of(i));
      end
    end
  endtask

  task automatic test_random();
    int t, b0, r0, mb0, h;
    bit ok;
    logic [7:0] tx, sb;
    for (int i = 0; i < NI; i++) begin
      h = h_of(i);
      src[i] = 0;
      realign(i);
      mb0 = mosi_bad[i];
      for (int j = 0; j < 8; j++) begin
        tx = 8'($urandom);
        sb = 8'($urandom);
        slave_byte[i][n_slave[i]] = sb;
        n_slave[i]++;
        repeat ($urandom_range(0, 3)) tick();
        b0 = n_bit[i]; r0 = n_rxdv[i];
        start(i, tx, t);
        wait_rxdv(i, r0 + 1, ok);
        n_vec++;
        if (!ok || rxdv_val[i][r0] !== sb || rxdv_cyc[i][r0] != t + 16 * h + 1) begin
          n_err++;
          $display("FAIL rand%0d_rx: spirx %h at %0d want %h at %0d", i, rxdv_val[i][r0],
                   rxdv_cyc[i][r0], sb, t + 16 * h + 1);
        end
        n_vec++;
        if (bits_byte(i, b0) !== tx) begin
          n_err++;
          $display("FAIL rand%0d_mosi: slave got %h want %h", i, bits_byte(i, b0), tx);
        end
      end
      n_vec++;
      if (mosi_bad[i] != mb0) begin
        n_err++;
        $display("FAIL rand%0d_mosi_edge: off-edge changes %0d want 0", i, mosi_bad[i] - mb0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] txs [3];
    logic [7:0] sbs [3];
    int ts [3];
    int e0, b0, r0, h, nbad;
    bit ok;
    txs[0] = 8'h80; txs[1] = 8'h01; txs[2] = 8'h5A;
    for (int i = 0; i < NI; i++) begin
      h = h_of(i);
      src[i] = 0;
      realign(i);
      for (int j = 0; j < 3; j++) begin
        sbs[j] = 8'($urandom);
        slave_byte[i][j] = sbs[j];
      end
      n_slave[i] = 3;
      tick();
      e0 = n_edge[i]; b0 = n_bit[i]; r0 = n_rxdv[i];
      for (int j = 0; j < 3; j++) start(i, txs[j], ts[j]);
      wait_rxdv(i, r0 + 3, ok);
      nbad = 0;
      for (int j = 0; j < 3; j++) begin
        if (j > 0 && ts[j] != ts[j - 1] + 16 * h + 1) nbad++;
        if (rxdv_cyc[i][r0 + j] != ts[0] + (j + 1) * (16 * h + 1)) nbad++;
      end
      n_vec++;
      if (!ok || nbad != 0) begin
        n_err++;
        $display("FAIL b2b%0d_spacing: %0d timing errors, want 0 (done=%0b)", i, nbad, ok);
      end
      nbad = 0;
      for (int j = 0; j < 3; j++)
        for (int k = 1; k <= 16; k++)
          if (edge_cyc[i][e0 + 16 * j + k - 1] != ts[j] + h * k) nbad++;
      n_vec++;
      if (n_edge[i] - e0 != 48 || nbad != 0) begin
        n_err++;
        $display("FAIL b2b%0d_edges: count=%0d misplaced=%0d want 48/0", i, n_edge[i] - e0, nbad);
      end
      for (int j = 0; j < 3; j++) begin
        n_vec++;
        if (rxdv_val[i][r0 + j] !== sbs[j] || bits_byte(i, b0 + 8 * j) !== txs[j]) begin
          n_err++;
          $display("FAIL b2b%0d_data%0d: spirx %h mosi %h want %h %h", i, j, rxdv_val[i][r0 + j],
                   bits_byte(i, b0 + 8 * j), sbs[j], txs[j]);
        end
      end
    end
  endtask

  task automatic test_ignore();
    int t, b0, r0;
    bit ok;
    src[0] = 1;
    b0 = n_bit[0]; r0 = n_rxdv[0];
    start(0, 8'h12, t);
    while (cyc < t + 5) tick();
    spitx[0]   = 8'hFF;
    spitxdv[0] = 1'b1;
    tick();
    spitxdv[0] = 1'b0;
    wait_rxdv(0, r0 + 1, ok);
    repeat (40) tick();
    n_vec++;
    if (n_rxdv[0] - r0 != 1 || rxdv_val[0][r0] !== 8'h12 || rxdv_cyc[0][r0] != t + 33) begin
      n_err++;
      $display("FAIL ignore_rx: pulses=%0d spirx=%h at %0d want 1 12 at %0d", n_rxdv[0] - r0,
               rxdv_val[0][r0], rxdv_cyc[0][r0], t + 33);
    end
    n_vec++;
    if (n_bit[0] - b0 != 8 || bits_byte(0, b0) !== 8'h12) begin
      n_err++;
      $display("FAIL ignore_mosi: bits=%0d byte=%h want 8/12", n_bit[0] - b0, bits_byte(0, b0));
    end
  endtask

  task automatic test_reset_mid();
    int t, b0, r0;
    bit ok;
    src[0] = 1;
    r0 = n_rxdv[0];
    start(0, 8'h96, t);
    while (cyc < t + 10) tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if (sclk[0] !== 1'b0 || spitxready[0] !== 1'b0 || spirxdv[0] !== 1'b0 || spirx[0] !== 8'h00)
    begin
      n_err++;
      $display("FAIL midrst_state: sclk=%b ready=%b rxdv=%b spirx=%h want 0 0 0 00", sclk[0],
               spitxready[0], spirxdv[0], spirx[0]);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (spitxready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_ready: got %b want 1", spitxready[0]);
    end
    repeat (60) tick();
    n_vec++;
    if (n_rxdv[0] != r0) begin
      n_err++;
      $display("FAIL midrst_no_rxdv: got %0d pulses want 0", n_rxdv[0] - r0);
    end
    b0 = n_bit[0];
    start(0, 8'hC3, t);
    wait_rxdv(0, r0 + 1, ok);
    n_vec++;
    if (!ok || rxdv_val[0][r0] !== 8'hC3 || rxdv_cyc[0][r0] != t + 33 ||
        bits_byte(0, b0) !== 8'hC3) begin
      n_err++;
      $display("FAIL midrst_after: spirx=%h at %0d mosi=%h want c3 at %0d c3", rxdv_val[0][r0],
               rxdv_cyc[0][r0], bits_byte(0, b0), t + 33);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      spitx[i]   = 8'h00;
      spitxdv[i] = 1'b0;
      src[i]     = 1;
      n_slave[i] = 0;
      sbase[i]   = 0;
    end
    test_reset();
    test_mode0_loopback();
    test_mode13();
    test_random();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (hold_bad[i] != 0) begin
        n_err++;
        $display("FAIL spirx_hold[%0d]: %0d changes outside spirxdv want 0", i, hold_bad[i]);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/adc_spi_master.md
Name: adc_spi_master

Overview:
Byte-wide SPI master that executes the ADC register read/write byte transfers requested by the command processor. It uses the spitx/spitxdv/spitxready/spirx/spirxdv handshake, with one byte per handshake. It generates sclk and mosi and samples miso. Chip select stays with the command processor, which holds it low across the 3-byte ADC transaction; this block never touches it.

Parameters:
SPI_MODE  0  SPI mode 0..3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
CLKS_PER_HALF_BIT  2  clk cycles per sclk half-period (H); legal values >= 2

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  reset; one clock; reset is synchronous and active-high
spitx  input  8  byte to transmit, MSB first; sampled only on acceptance
spitxdv  input  1  transmit request; accepted when spitxdv & spitxready
spitxready  output  1  high when idle and able to accept a byte
spirx  output  8  last received byte; held until the next transfer completes
spirxdv  output  1  one-cycle pulse: spirx valid, transfer complete
spibusy  output  1  high while a transfer is in progress (= ~spitxready after reset)
sclk  output  1  SPI clock; idles at CPOL
mosi  output  1  SPI data out
miso  input  1  SPI data in (already synchronous to clk at this rate)

Behaviour:
- Reset (rst high at a posedge): spitxready=0, spibusy=0, spirxdv=0, spirx=8'h00, sclk=CPOL, mosi=0, and all counters cleared. In the first cycle after rst deasserts, spitxready=1.
- States: IDLE, SHIFT, DONE.
- IDLE: spitxready=1, sclk=CPOL.
  - On spitxdv=1 at edge T: latch spitx into the shift register and clear the edge count to 0.
  - Go to SHIFT; spitxready=0 from T+1.
  - CPHA=0: mosi=spitx[7] from T+1.
  - CPHA=1: mosi holds its prior value until edge 1.
- SHIFT:
  - Half-bit counter counts H cycles; sclk toggles at T+k*H for k=1..16 (edges 1..16).
  - Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0: sample miso on leading edges (bit 7 first); drive the next mosi bit on trailing edges 2,4,..,14. Mosi is unchanged at edge 16.
  - CPHA=1: drive mosi on leading edges (bit 7 at edge 1); sample miso on trailing edges.
  - Sampled miso shifts into the receive register LSB-in, so the first sampled bit ends up in bit 7.
  - After edge 16, sclk=CPOL; go to DONE.
- DONE (one cycle, at T+16H+1): spirx = received byte, spirxdv=1, spitxready=1, spibusy=0. Next state is IDLE.
  - A spitxdv accepted in this cycle starts a new transfer immediately, with no extra idle cycle; timing then repeats from this cycle as the new T.
- Latency: acceptance at T to spirxdv at T+16H+1. For H=2 that is T+33.
- spitxdv while spitxready=0 is ignored: no queueing, no error.
- spitx changes during a transfer have no effect.
- spirxdv is exactly one cycle per completed transfer and never asserts for an aborted one.
- Reset mid-transfer: the next cycle shows reset values, sclk returns to CPOL, and no spirxdv is produced.
- spirx keeps its value across IDLE and through the next transfer until the next DONE.
- Mosi holds its last driven bit in IDLE. The ADC ignores it with CS high.
- No combinational path from any input to any output. All outputs are registered except spitxready/spibusy, which are decoded from state registers only.

Test Plan:
- Mode 0, H=2, miso looped back from mosi, send 8'hA5 accepted at T:
  - Expect 16 sclk edges at T+2..T+32.
  - Expect the mosi bit sequence 1,0,1,0,0,1,0,1.
  - Expect spirxdv at T+33 with spirx=8'hA5 and spitxready=1 in the same cycle.
- Mode 1 and mode 3, H=3, miso tied 1, send 8'h3C:
  - Expect spirx=8'hFF and spirxdv at T+49.
  - Expect sclk idling at 0 (mode 1) or 1 (mode 3) before and after.
  - Expect mosi changing only on leading edges.
- Back-to-back transfers: 8'h80, 8'h01, 8'h5A, each spitxdv asserted in the cycle spitxready rises.
  - Expect three spirxdv pulses spaced exactly 16H+1 cycles apart.
  - Expect continuous sclk bursts with no extra gap cycles.
- spitxdv pulsed with spitx=8'hFF at T+5 during a transfer of 8'h12:
  - Ignored: transmitted byte remains 8'h12 and only one spirxdv occurs.
- rst asserted at T+10 of a transfer:
  - Next cycle: sclk=CPOL, spitxready=0, spirxdv never pulses.
  - After release, a fresh 8'hC3 transfer completes correctly with spirx=8'hC3 (loopback).
